irig_b_encoder: RTL and testbench



---
 rtl/irig_b_encoder.sv | 203 ++++++++++++++++++++
 tb/tb_irig_b_encoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/irig_b_encoder.sv
// rtl/irig_b_encoder.sv - IRIG-B DC level-shift time code generator with settable time of day
module irig_b_encoder #(
    parameter int CLK_HZ = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       set_stb,
    input  logic [5:0] set_sec,
    input  logic [5:0] set_min,
    input  logic [4:0] set_hour,
    input  logic [8:0] set_day,
    input  logic [6:0] set_year,
    output logic       set_err,
    output logic       irig_out,
    output logic       pps,
    output logic [5:0] cur_sec,
    output logic [5:0] cur_min,
    output logic [4:0] cur_hour,
    output logic [8:0] cur_day,
    output logic [6:0] cur_year
);

    localparam int MS_CYC  = CLK_HZ / 1000;
    localparam int BIT_CYC = 10 * MS_CYC;
    localparam int CW      = $clog2(BIT_CYC);

    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] W_MARK   = CW'(8 * MS_CYC);
    localparam logic [CW-1:0] W_ONE    = CW'(5 * MS_CYC);
    localparam logic [CW-1:0] W_ZERO   = CW'(2 * MS_CYC);

    function automatic logic [3:0] bcd_u(input logic [8:0] v);
        return 4'(v % 9'd10);
    endfunction

    function automatic logic [3:0] bcd_t(input logic [8:0] v);
        return 4'((v / 9'd10) % 9'd10);
    endfunction

    function automatic logic [3:0] bcd_h(input logic [8:0] v);
        return 4'(v / 9'd100);
    endfunction

    function automatic logic is_marker(input logic [6:0] b);
        return (b == 7'd0) || ((b % 7'd10) == 7'd9);
    endfunction

    logic [CW-1:0] cyc_cnt, cyc_nxt;
    logic [6:0]    bit_idx, bit_nxt;
    logic          run_q;
    logic          pending;
    logic          boundary;
    logic          set_ok;
    logic [8:0]    cur_last, set_last;
    logic [CW-1:0] w_nxt;
    logic [99:0]   frame;

    logic [5:0] sh_sec, sh_min;
    logic [4:0] sh_hour;
    logic [8:0] sh_day;
    logic [6:0] sh_year;

    logic [5:0] inc_sec, inc_min;
    logic [4:0] inc_hour;
    logic [8:0] inc_day;
    logic [6:0] inc_year;

    assign cur_last = (cur_year[1:0] == 2'b00) ? 9'd366 : 9'd365;
    assign set_last = (set_year[1:0] == 2'b00) ? 9'd366 : 9'd365;

    assign set_ok = (set_sec <= 6'd59) && (set_min <= 6'd59) && (set_hour <= 5'd23) &&
                    (set_day >= 9'd1) && (set_day <= set_last) && (set_year <= 7'd99);

    assign boundary = enable && run_q && (bit_idx == 7'd99) && (cyc_cnt == CYC_LAST);

    // Counters sit at zero until the first enabled edge, which itself presents bit 0.
    always_comb begin
        cyc_nxt = '0;
        bit_nxt = '0;
        if (enable && run_q) begin
            if (cyc_cnt == CYC_LAST) begin
                cyc_nxt = '0;
                bit_nxt = (bit_idx == 7'd99) ? 7'd0 : bit_idx + 7'd1;
            end else begin
                cyc_nxt = cyc_cnt + CW'(1);
                bit_nxt = bit_idx;
            end
        end
    end

    // Time only changes when bit 0 (a marker) starts, so the frame can be built from cur_*.
    always_comb begin
        frame        = '0;
        frame[4:1]   = bcd_u({3'b000, cur_sec});
        frame[9:6]   = bcd_t({3'b000, cur_sec});
        frame[13:10] = bcd_u({3'b000, cur_min});
        frame[18:15] = bcd_t({3'b000, cur_min});
        frame[23:20] = bcd_u({4'b0000, cur_hour});
        frame[28:25] = bcd_t({4'b0000, cur_hour});
        frame[33:30] = bcd_u(cur_day);
        frame[38:35] = bcd_t(cur_day);
        frame[43:40] = bcd_h(cur_day);
        frame[53:50] = bcd_u({2'b00, cur_year});
        frame[58:55] = bcd_t({2'b00, cur_year});
    end

    always_comb begin
        w_nxt = W_ZERO;
        if (is_marker(bit_nxt))
            w_nxt = W_MARK;
        else if (frame[bit_nxt])
            w_nxt = W_ONE;
    end

    always_comb begin
        inc_sec  = cur_sec;
        inc_min  = cur_min;
        inc_hour = cur_hour;
        inc_day  = cur_day;
        inc_year = cur_year;
        if (cur_sec != 6'd59) begin
            inc_sec = cur_sec + 6'd1;
        end else begin
            inc_sec = '0;
            if (cur_min != 6'd59) begin
                inc_min = cur_min + 6'd1;
            end else begin
                inc_min = '0;
                if (cur_hour != 5'd23) begin
                    inc_hour = cur_hour + 5'd1;
                end else begin
                    inc_hour = '0;
                    if (cur_day != cur_last) begin
                        inc_day = cur_day + 9'd1;
                    end else begin
                        inc_day  = 9'd1;
                        inc_year = (cur_year == 7'd99) ? 7'd0 : cur_year + 7'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt  <= '0;
            bit_idx  <= '0;
            run_q    <= 1'b0;
            irig_out <= 1'b0;
            pps      <= 1'b0;
            set_err  <= 1'b0;
            pending  <= 1'b0;
            sh_sec   <= '0;
            sh_min   <= '0;
            sh_hour  <= '0;
            sh_day   <= 9'd1;
            sh_year  <= '0;
            cur_sec  <= '0;
            cur_min  <= '0;
            cur_hour <= '0;
            cur_day  <= 9'd1;
            cur_year <= '0;
        end else begin
            run_q    <= enable;
            cyc_cnt  <= cyc_nxt;
            bit_idx  <= bit_nxt;
            irig_out <= enable && (cyc_nxt < w_nxt);
            pps      <= enable && (bit_nxt == 7'd0) && (cyc_nxt == '0);
            set_err  <= set_stb && !set_ok;
            if (boundary) begin
                pending <= 1'b0;
                if (set_stb && set_ok) begin
                    cur_sec  <= set_sec;
                    cur_min  <= set_min;
                    cur_hour <= set_hour;
                    cur_day  <= set_day;
                    cur_year <= set_year;
                end else if (pending) begin
                    cur_sec  <= sh_sec;
                    cur_min  <= sh_min;
                    cur_hour <= sh_hour;
                    cur_day  <= sh_day;
                    cur_year <= sh_year;
                end else begin
                    cur_sec  <= inc_sec;
                    cur_min  <= inc_min;
                    cur_hour <= inc_hour;
                    cur_day  <= inc_day;
                    cur_year <= inc_year;
                end
            end else if (set_stb && set_ok) begin
                pending <= 1'b1;
                sh_sec  <= set_sec;
                sh_min  <= set_min;
                sh_hour <= set_hour;
                sh_day  <= set_day;
                sh_year <= set_year;
            end
        end
    end

endmodule

// File: tb/tb_irig_b_encoder.sv
// tb/tb_irig_b_encoder.sv - directed self-checking bench for irig_b_encoder at a 1 kHz clock
module tb_irig_b_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       set_stb;
    logic [5:0] set_sec, set_min;
    logic [4:0] set_hour;
    logic [8:0] set_day;
    logic [6:0] set_year;
    logic       set_err, irig_out, pps;
    logic [5:0] cur_sec, cur_min;
    logic [4:0] cur_hour;
    logic [8:0] cur_day;
    logic [6:0] cur_year;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic samples [1000];

    irig_b_encoder #(.CLK_HZ(1000)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .set_stb  (set_stb),
        .set_sec  (set_sec),
        .set_min  (set_min),
        .set_hour (set_hour),
        .set_day  (set_day),
        .set_year (set_year),
        .set_err  (set_err),
        .irig_out (irig_out),
        .pps      (pps),
        .cur_sec  (cur_sec),
        .cur_min  (cur_min),
        .cur_hour (cur_hour),
        .cur_day  (cur_day),
        .cur_year (cur_year)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pps();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!pps && k < 2100);
        check("pps_seen", 32'(pps), 32'd1);
    endtask

    // Starts on the pps cycle, ends on the last cycle of the frame.
    task automatic capture();
        for (int i = 0; i < 1000; i++) begin
            samples[i] = irig_out;
            if (i < 999) @(negedge clk);
        end
    endtask

    function automatic int high_cnt(input int b);
        int c;
        c = 0;
        for (int i = 0; i < 10; i++)
            if (samples[b*10 + i]) c++;
        return c;
    endfunction

    function automatic int field(input int lo, input int n);
        int v;
        v = 0;
        for (int i = 0; i < n; i++)
            if (high_cnt(lo + i) == 5) v += (1 << i);
        return v;
    endfunction

    task automatic do_set(input int s, input int m, input int h, input int d, input int y);
        set_sec  = 6'(s);
        set_min  = 6'(m);
        set_hour = 5'(h);
        set_day  = 9'(d);
        set_year = 7'(y);
        set_stb  = 1'b1;
        @(negedge clk);
        set_stb  = 1'b0;
    endtask

    task automatic check_time(input string tag, input int s, input int m, input int h,
                              input int d, input int y);
        check({tag, "_sec"},  32'(cur_sec),  32'(s));
        check({tag, "_min"},  32'(cur_min),  32'(m));
        check({tag, "_hour"}, 32'(cur_hour), 32'(h));
        check({tag, "_day"},  32'(cur_day),  32'(d));
        check({tag, "_year"}, 32'(cur_year), 32'(y));
    endtask

    task automatic check_frame(input string tag, input int s, input int m, input int h,
                               input int d, input int y);
        int mk;
        mk = 0;
        for (int b = 0; b < 100; b++)
            if (b == 0 || b % 10 == 9)
                if (high_cnt(b) == 8) mk++;
        check({tag, "_markers"}, 32'(mk), 32'd11);
        check({tag, "_fsec"},  32'(field(1, 4) + 10 * field(6, 3)), 32'(s));
        check({tag, "_fmin"},  32'(field(10, 4) + 10 * field(15, 3)), 32'(m));
        check({tag, "_fhour"}, 32'(field(20, 4) + 10 * field(25, 2)), 32'(h));
        check({tag, "_fday"},  32'(field(30, 4) + 10 * field(35, 4) + 100 * field(40, 2)), 32'(d));
        check({tag, "_fyear"}, 32'(field(50, 4) + 10 * field(55, 4)), 32'(y));
        check({tag, "_bit5"},  32'(high_cnt(5)), 32'd2);
        check({tag, "_bit64"}, 32'(high_cnt(64)), 32'd2);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; set_stb = 1'b0;
        set_sec = '0; set_min = '0; set_hour = '0; set_day = 9'd1; set_year = '0;
        tick(3);
        check("rst_irig", 32'(irig_out), 32'd0);
        check("rst_pps", 32'(pps), 32'd0);
        check("rst_err", 32'(set_err), 32'd0);
        check_time("rst", 0, 0, 0, 1, 0);
        rst = 1'b0;
        tick(3);
        check("dis_irig", 32'(irig_out), 32'd0);

        // First frame starts on the first enabled edge.
        enable = 1'b1;
        wait_pps();
        check("f1_irig0", 32'(irig_out), 32'd1);
        capture();
        check("f1_bit0", 32'(high_cnt(0)), 32'd8);
        check("f1_bit1", 32'(high_cnt(1)), 32'd2);
        check("f1_bit30", 32'(high_cnt(30)), 32'd5);
        check_frame("f1", 0, 0, 0, 1, 0);
        wait_pps();
        check("f2_sec", 32'(cur_sec), 32'd1);
        capture();
        check("f2_bit1", 32'(high_cnt(1)), 32'd5);

        // Year-end rollover, non-leap then leap.
        tick(100);
        do_set(59, 59, 23, 365, 23);
        check("set1_err", 32'(set_err), 32'd0);
        wait_pps();
        check_time("s1", 59, 59, 23, 365, 23);
        capture();
        check_frame("s1", 59, 59, 23, 365, 23);
        wait_pps();
        check_time("roll1", 0, 0, 0, 1, 24);
        tick(100);
        do_set(59, 59, 23, 365, 24);
        wait_pps();
        check_time("s2", 59, 59, 23, 365, 24);
        wait_pps();
        check_time("roll2", 0, 0, 0, 366, 24);

        // BCD layout of 12:34:56 day 257 year 99.
        tick(100);
        do_set(56, 34, 12, 257, 99);
        wait_pps();
        check_time("s3", 56, 34, 12, 257, 99);
        capture();
        check("s3_secu", 32'(field(1, 4)), 32'd6);
        check("s3_sect", 32'(field(6, 3)), 32'd5);
        check("s3_dayu", 32'(field(30, 4)), 32'd7);
        check("s3_dayt", 32'(field(35, 4)), 32'd5);
        check("s3_dayh", 32'(field(40, 2)), 32'd2);
        check("s3_yru", 32'(field(50, 4)), 32'd9);
        check("s3_yrt", 32'(field(55, 4)), 32'd9);
        check_frame("s3", 56, 34, 12, 257, 99);

        // Rejected sets leave time and pending untouched.
        tick(50);
        do_set(0, 0, 0, 366, 23);
        check("inv_day_err", 32'(set_err), 32'd1);
        tick(1);
        check("inv_err_pulse", 32'(set_err), 32'd0);
        do_set(0, 0, 24, 1, 0);
        check("inv_hour_err", 32'(set_err), 32'd1);
        check_time("inv", 57, 34, 12, 257, 99);
        wait_pps();
        check_time("inv_next", 58, 34, 12, 257, 99);

        // Set landing exactly on the boundary cycle.
        tick(999);
        set_sec = 6'd3; set_min = 6'd2; set_hour = 5'd1; set_day = 9'd10; set_year = 7'd5;
        set_stb = 1'b1;
        @(negedge clk);
        set_stb = 1'b0;
        check("bnd_pps", 32'(pps), 32'd1);
        check_time("bnd", 3, 2, 1, 10, 5);
        wait_pps();
        check_time("bnd_next", 4, 2, 1, 10, 5);

        // Abort at bit 45 and resend the same time.
        tick(451);
        check("ab_irig_hi", 32'(irig_out), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("ab_irig_lo", 32'(irig_out), 32'd0);
        tick(5);
        check("ab_hold", 32'(irig_out), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check("re_pps", 32'(pps), 32'd1);
        check("re_irig", 32'(irig_out), 32'd1);
        check_time("re", 4, 2, 1, 10, 5);

        // Asynchronous reset mid-bit.
        tick(3);
        check("mid_irig", 32'(irig_out), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_irig", 32'(irig_out), 32'd0);
        check("arst_pps", 32'(pps), 32'd0);
        check_time("arst", 0, 0, 0, 1, 0);
        tick(2);
        rst = 1'b0;
        enable = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
